neuron_layer_seq: RTL and testbench

Sequencer that time-multiplexes one `neuron_intra_Nbits` datapath across the N_NEURONS neurons of a fully connected layer. On `start` it streams weight-vector addresses to a synchronous weight memory, drives the datapath `en`, tracks the three-stage pipeline (memory read, `acc`, `Out`), and writes each saturated-ReLU result to the layer output buffer. It sits between the layer-level top controller (start/done) and the neuron datapath plus weight ROM.

---
 rtl/neuron_layer_seq.sv | 108 ++++++++++
 tb/tb_neuron_layer_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_layer_seq.sv
// Layer sequencer: time-multiplexes one neuron datapath over N_NEURONS weight vectors.
// Optional macro NEURON_LAYER_SEQ_STALL_EN adds a 'stall' input that freezes the pass.
module neuron_layer_seq #(
  parameter int N         = 8,
  parameter int N_NEURONS = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef NEURON_LAYER_SEQ_STALL_EN
  input  logic              stall,
`endif
  output logic              busy,
  output logic              done,
  output logic              x_ld,
  output logic              w_rd,
  output logic [ADDR_W-1:0] w_addr,
  output logic              neuron_en,
  input  logic [N-1:0]      neuron_out,
  output logic              y_we,
  output logic [ADDR_W-1:0] y_addr,
  output logic [N-1:0]      y_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NEURONS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_issue;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic              r_s1;
  logic              r_s2;
  logic              r_s3;
  logic              r_done;
  logic              w_stall;
  logic              w_run;
  logic              w_accept;
  logic              w_issue;
  logic              w_last_wr;

`ifdef NEURON_LAYER_SEQ_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_run     = ~w_stall;
  assign w_accept  = (r_state == S_IDLE) && start && w_run;
  assign w_issue   = (r_state == S_FILL);
  // Final write is the cycle where only s3 is still valid in the pipeline.
  assign w_last_wr = r_s3 && !r_s2 && !r_s1;

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_FILL;
      S_FILL:  if (w_run && (r_issue == LAST_IDX)) w_next = S_DRAIN;
      S_DRAIN: if (w_run && w_last_wr) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state  <= S_IDLE;
      r_issue  <= '0;
      r_wr_cnt <= '0;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_s3     <= 1'b0;
      r_done   <= 1'b0;
    end else if (w_run) begin
      r_state <= w_next;
      r_s1    <= w_issue;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_done  <= (r_state == S_DRAIN) && w_last_wr;
      if (w_accept)
        r_issue <= '0;
      else if (w_issue)
        r_issue <= r_issue + 1'b1;
      if (w_accept)
        r_wr_cnt <= '0;
      else if (r_s3)
        r_wr_cnt <= r_wr_cnt + 1'b1;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign x_ld      = w_accept && !rst;
  assign w_rd      = w_issue && w_run;
  assign w_addr    = r_issue;
  assign neuron_en = (r_s1 || r_s2) && w_run;
  assign y_we      = r_s3 && w_run;
  assign y_addr    = r_wr_cnt;
  assign y_data    = neuron_out;
  assign done      = r_done && w_run;

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Bench for neuron_layer_seq: 16-neuron and 1-neuron instances driving a behavioural
// weight ROM + neuron pipeline; per-cycle vector table plus directed corner sequences.
module tb_neuron_layer_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, start1;
  logic       busy, done, x_ld, w_rd, neuron_en, y_we;
  logic [3:0] w_addr, y_addr;
  logic [7:0] neuron_out, y_data;
  logic       busy1, done1, x_ld1, w_rd1, neuron_en1, y_we1;
  logic [0:0] w_addr1, y_addr1;
  logic [7:0] neuron_out1, y_data1;
`ifdef NEURON_LAYER_SEQ_STALL_EN
  logic       stall;
  logic       stall1;
`endif

  neuron_layer_seq #(.N(8), .N_NEURONS(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef NEURON_LAYER_SEQ_STALL_EN
    .stall(stall),
`endif
    .busy(busy), .done(done), .x_ld(x_ld), .w_rd(w_rd), .w_addr(w_addr),
    .neuron_en(neuron_en), .neuron_out(neuron_out), .y_we(y_we),
    .y_addr(y_addr), .y_data(y_data)
  );

  neuron_layer_seq #(.N(8), .N_NEURONS(1), .ADDR_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
`ifdef NEURON_LAYER_SEQ_STALL_EN
    .stall(stall1),
`endif
    .busy(busy1), .done(done1), .x_ld(x_ld1), .w_rd(w_rd1), .w_addr(w_addr1),
    .neuron_en(neuron_en1), .neuron_out(neuron_out1), .y_we(y_we1),
    .y_addr(y_addr1), .y_data(y_data1)
  );

  assign neuron_out1 = 8'd42;

  // Behavioural weight ROM (word = dot product) and neuron acc/Out stages.
  int         rom [16];
  int         mem_q = 0;
  int         acc_q = 0;
  logic [7:0] out_q = 8'd0;

  function automatic logic [7:0] relu_sat(input int v);
    if (v < 0)   return 8'd0;
    if (v > 127) return 8'd127;
    return 8'(v);
  endfunction

  always @(posedge clk) begin
    if (w_rd) mem_q <= rom[w_addr];
    if (neuron_en) begin
      acc_q <= mem_q;
      out_q <= relu_sat(acc_q);
    end
  end
  assign neuron_out = out_q;

  int tick = 0;
  int t0   = 0;
  always @(posedge clk) tick <= tick + 1;

  logic [7:0] wr_data [256];
  logic [3:0] wr_addr [256];
  int         wr_n   = 0;
  int         done_n = 0;
  always @(negedge clk) begin
    if (y_we && wr_n < 256) begin
      wr_data[wr_n] <= y_data;
      wr_addr[wr_n] <= y_addr;
      wr_n          <= wr_n + 1;
    end
    if (done) done_n <= done_n + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0] ctl;    // {busy, done, w_rd, neuron_en, y_we}
    logic [3:0] waddr;
    logic [3:0] yaddr;
    logic [7:0] ydata;
  } vec_t;

  vec_t vec [20];
  vec_t vec1 [6];
  int   exp_y [16] = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};

  task automatic start_pass();
    @(negedge clk);
    start = 1'b1;
    #1;
    check("x_ld on accept", x_ld, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    t0    = tick;
  endtask

  task automatic run_table(input string tag);
    logic [4:0] obs;
    start_pass();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      obs = {busy, done, w_rd, neuron_en, y_we};
      check($sformatf("%s ctl c%0d", tag, c), obs, vec[c].ctl);
      if (vec[c].ctl[2]) check($sformatf("%s w_addr c%0d", tag, c), w_addr, vec[c].waddr);
      if (vec[c].ctl[0]) begin
        check($sformatf("%s y_addr c%0d", tag, c), y_addr, vec[c].yaddr);
        check($sformatf("%s y_data c%0d", tag, c), y_data, vec[c].ydata);
      end
    end
    @(negedge clk);
    check($sformatf("%s idle after done", tag), busy, 0);
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        dcyc = tick - t0;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base, dcyc, xl, snap_w, snap_d;
    int sat_in  [5] = '{300, -50, 127, 128, -1};
    int sat_exp [5] = '{127, 0, 127, 127, 0};

    for (int k = 0; k < 16; k++) rom[k] = k - 3;
    for (int c = 0; c < 20; c++) begin
      vec[c].ctl   = {c <= 18, c == 19, c < 16, (c >= 1) && (c <= 17), (c >= 3) && (c <= 18)};
      vec[c].waddr = 4'(c);
      vec[c].yaddr = 4'(c - 3);
      vec[c].ydata = (c >= 3 && c <= 18) ? 8'(exp_y[c - 3]) : 8'd0;
    end
    for (int c = 0; c < 6; c++) begin
      vec1[c].ctl   = {c <= 3, c == 4, c == 0, (c >= 1) && (c <= 2), c == 3};
      vec1[c].waddr = 4'd0;
      vec1[c].yaddr = 4'd0;
      vec1[c].ydata = 8'd42;
    end

    rst    = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
`ifdef NEURON_LAYER_SEQ_STALL_EN
    stall  = 1'b0;
    stall1 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset outputs", {busy, done, x_ld, w_rd, neuron_en, y_we, w_addr, y_addr}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle outputs", {busy, done, x_ld, w_rd, neuron_en, y_we, w_addr, y_addr}, 0);

    // Main 16-neuron pass against the per-cycle table.
    run_table("pass1");

    // Saturation at both ends.
    for (int i = 0; i < 5; i++) rom[i] = sat_in[i];
    base = wr_n;
    start_pass();
    wait_done(40, dcyc);
    check("sat done cycle", dcyc, 19);
    check("sat write count", wr_n - base, 16);
    for (int i = 0; i < 5; i++)
      check($sformatf("sat value %0d", i), wr_data[base + i], sat_exp[i]);
    for (int k = 0; k < 16; k++) rom[k] = k - 3;

    // start held high: back-to-back passes, extra start ignored while busy.
    base = wr_n;
    @(negedge clk);
    start = 1'b1;
    #1;
    xl = x_ld ? 1 : 0;
    @(posedge clk);
    #1;
    t0 = tick;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (x_ld) xl++;
      if (c == 19) check("b2b first done", done, 1);
      if (c == 20) check("b2b second cycle0", {busy, w_rd, w_addr}, {1'b1, 1'b1, 4'd0});
      if (c == 39) check("b2b second done", done, 1);
      if (c == 38) start = 1'b0;
    end
    check("b2b x_ld pulses", xl, 2);
    check("b2b write count", wr_n - base, 32);
    @(negedge clk);
    check("b2b idle after", busy, 0);

    // Reset in cycle 7 aborts the pass.
    start_pass();
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid-pass reset outputs", {busy, done, x_ld, w_rd, neuron_en, y_we, w_addr, y_addr}, 0);
    @(negedge clk);
    rst = 1'b0;
    snap_w = wr_n;
    snap_d = done_n;
    repeat (25) @(negedge clk);
    check("no writes after reset", wr_n - snap_w, 0);
    check("no done after reset", done_n - snap_d, 0);
    run_table("after_rst");

    // Single-neuron instance.
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("n1 ctl c%0d", c), {busy1, done1, w_rd1, neuron_en1, y_we1}, vec1[c].ctl);
      if (vec1[c].ctl[0]) check("n1 y_data", {y_addr1, y_data1}, {1'b0, vec1[c].ydata});
    end

`ifdef NEURON_LAYER_SEQ_STALL_EN
    // Stall cycles 5..8: same results, done shifted by 4.
    base = wr_n;
    start_pass();
    dcyc = -1;
    for (int i = 0; i < 40 && dcyc < 0; i++) begin
      @(negedge clk);
      if ((tick - t0) >= 5 && (tick - t0) <= 8)
        check($sformatf("stall quiet c%0d", tick - t0), {w_rd, neuron_en, y_we, done}, 0);
      if (done) dcyc = tick - t0;
      @(posedge clk);
      #1;
      if (tick - t0 == 5) stall = 1'b1;
      if (tick - t0 == 9) stall = 1'b0;
    end
    check("stall done cycle", dcyc, 23);
    check("stall write count", wr_n - base, 16);
    for (int k = 0; k < 16; k++)
      check($sformatf("stall write %0d", k), {wr_addr[base + k], wr_data[base + k]},
            {4'(k), 8'(exp_y[k])});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
